// File: rtl/psk_frame_arbiter.sv
// Frame-locked round-robin arbiter sharing the 1 MHz symbol stream between two sources.
// Zero-latency pass-through while granted; tready follows downstream only for the granted source.
module psk_frame_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int GAP_TICKS     = 4,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce_1m,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic                  s0_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic                  s1_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [15:0]           frame_count,
    output logic                  timeout_pulse,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

    localparam logic [7:0]  GAP_END = 8'(GAP_TICKS);
    localparam logic [15:0] TMO_END = 16'(TIMEOUT_TICKS);
    localparam state_t      POST_ST = (GAP_TICKS > 0) ? GAP : IDLE;

    state_t      state, state_nxt;
    logic        grant, grant_nxt;
    logic        last_grant, last_grant_nxt;
    logic [7:0]  gap_cnt, gap_cnt_nxt;
    logic [15:0] tmo_cnt, tmo_cnt_nxt;
    logic [15:0] frame_cnt;
    logic        frame_end;
    logic        tmo_fire;
    logic        sel_vld;
    logic        sel_last;

    assign sel_vld     = grant ? s1_axis_tvalid : s0_axis_tvalid;
    assign sel_last    = grant ? s1_axis_tlast  : s0_axis_tlast;
    assign frame_count = frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            gap_cnt       <= '0;
            tmo_cnt       <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            grant         <= grant_nxt;
            last_grant    <= last_grant_nxt;
            gap_cnt       <= gap_cnt_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            timeout_pulse <= tmo_fire;
        end
    end

    // Only written on a completed frame, so it holds between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        gap_cnt_nxt    = gap_cnt;
        tmo_cnt_nxt    = tmo_cnt;
        frame_end      = 1'b0;
        tmo_fire       = 1'b0;
        case (state)
            IDLE: begin
                if (ce_1m && (s0_axis_tvalid || s1_axis_tvalid)) begin
                    // Contention goes to whoever did not own the previous frame.
                    grant_nxt   = (s0_axis_tvalid && s1_axis_tvalid) ? ~last_grant : s1_axis_tvalid;
                    tmo_cnt_nxt = '0;
                    state_nxt   = GRANT;
                end
            end
            GRANT: begin
                if (ce_1m) begin
                    if (sel_vld) begin
                        tmo_cnt_nxt = '0;
                        if (m_axis_tready && sel_last) begin
                            frame_end      = 1'b1;
                            last_grant_nxt = grant;
                            gap_cnt_nxt    = '0;
                            state_nxt      = POST_ST;
                        end
                    end else if (tmo_cnt + 16'd1 == TMO_END) begin
                        tmo_fire       = 1'b1;
                        last_grant_nxt = grant;
                        gap_cnt_nxt    = '0;
                        tmo_cnt_nxt    = '0;
                        state_nxt      = POST_ST;
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + 16'd1;
                    end
                end
            end
            GAP: begin
                if (ce_1m) begin
                    gap_cnt_nxt = gap_cnt + 8'd1;
                    if (gap_cnt + 8'd1 == GAP_END) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_axis_tdata   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_tuser   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        busy           = (state != IDLE);
        if (state == GRANT) begin
            m_axis_tdata   = grant ? s1_axis_tdata : s0_axis_tdata;
            m_axis_tvalid  = sel_vld;
            m_axis_tlast   = sel_last;
            m_axis_tuser   = grant;
            s0_axis_tready = ~grant & m_axis_tready;
            s1_axis_tready = grant & m_axis_tready;
        end
    end

endmodule

// File: tb/tb_psk_frame_arbiter.sv
// Directed bench for psk_frame_arbiter: a default instance plus a zero-gap instance
// sharing the same stimulus; a mux selects whose outputs the source model follows.
module tb_psk_frame_arbiter;

    localparam int DW = 32;

    typedef struct packed {
        logic          user;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce_1m = 1'b0;
    logic [DW-1:0] s0_tdata = '0;
    logic [DW-1:0] s1_tdata = '0;
    logic          s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic          s0_tlast = 1'b0, s1_tlast = 1'b0;
    logic          m_tready = 1'b0;

    logic [DW-1:0] a_tdata, z_tdata;
    logic          a_tvalid, z_tvalid, a_tlast, z_tlast, a_tuser, z_tuser;
    logic          a_s0r, z_s0r, a_s1r, z_s1r, a_tp, z_tp, a_busy, z_busy;
    logic [15:0]   a_fc, z_fc;

    bit sel_z = 1'b0;

    wire [DW-1:0] o_tdata  = sel_z ? z_tdata  : a_tdata;
    wire          o_tvalid = sel_z ? z_tvalid : a_tvalid;
    wire          o_tlast  = sel_z ? z_tlast  : a_tlast;
    wire          o_tuser  = sel_z ? z_tuser  : a_tuser;
    wire          o_s0r    = sel_z ? z_s0r    : a_s0r;
    wire          o_s1r    = sel_z ? z_s1r    : a_s1r;
    wire          o_tp     = sel_z ? z_tp     : a_tp;
    wire          o_busy   = sel_z ? z_busy   : a_busy;
    wire [15:0]   o_fc     = sel_z ? z_fc     : a_fc;

    always #5 clk = ~clk;

    psk_frame_arbiter #(.DATA_WIDTH(DW), .GAP_TICKS(4), .TIMEOUT_TICKS(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .ce_1m(ce_1m),
        .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(a_s0r), .s0_axis_tlast(s0_tlast),
        .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(a_s1r), .s1_axis_tlast(s1_tlast),
        .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser),
        .frame_count(a_fc), .timeout_pulse(a_tp), .busy(a_busy)
    );

    psk_frame_arbiter #(.DATA_WIDTH(DW), .GAP_TICKS(0), .TIMEOUT_TICKS(64)) dut_z (
        .clk(clk), .rst_n(rst_n), .ce_1m(ce_1m),
        .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(z_s0r), .s0_axis_tlast(s0_tlast),
        .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(z_s1r), .s1_axis_tlast(s1_tlast),
        .m_axis_tdata(z_tdata), .m_axis_tvalid(z_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(z_tlast), .m_axis_tuser(z_tuser),
        .frame_count(z_fc), .timeout_pulse(z_tp), .busy(z_busy)
    );

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    beat_t       obs_q[$];
    int          tests = 0;
    int          fails = 0;
    int          tp_cnt = 0;
    bit          tp_seen, tp_after, busy_s, r0_seen;

    logic [31:0] rr_d [8] = '{32'h100, 32'h101, 32'h200, 32'h201, 32'h102, 32'h103, 32'h202, 32'h203};
    logic        rr_u [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        s0_tvalid = (q0.size() > 0);
        s0_tdata  = s0_tvalid ? q0[0][31:0] : '0;
        s0_tlast  = s0_tvalid ? q0[0][32] : 1'b0;
        s1_tvalid = (q1.size() > 0);
        s1_tdata  = s1_tvalid ? q1[0][31:0] : '0;
        s1_tlast  = s1_tvalid ? q1[0][32] : 1'b0;
    endtask

    // One ce_1m tick followed by one ce-low clock; called and returns at a negedge.
    task automatic tick();
        bit h0, h1;
        drive();
        ce_1m = 1'b1;
        #1;
        h0 = s0_tvalid && o_s0r;
        h1 = s1_tvalid && o_s1r;
        if (o_s0r) r0_seen = 1'b1;
        if (o_tvalid && m_tready) obs_q.push_back({o_tuser, o_tlast, o_tdata});
        @(negedge clk);
        tp_seen = o_tp;
        busy_s  = o_busy;
        if (o_tp) tp_cnt++;
        ce_1m = 1'b0;
        if (h0) q0.delete(0);
        if (h1) q1.delete(0);
        drive();
        @(negedge clk);
        tp_after = o_tp;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        obs_q.delete();
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        m_tready = 1'b1;
        q0.push_back({1'b0, 32'hA1});
        q0.push_back({1'b0, 32'hA2});
        q0.push_back({1'b1, 32'hA3});
        drive();
        repeat (3) @(negedge clk);

        // Reset state with s0 already requesting
        chk("rst_ctrl", 32'({o_tvalid, o_tlast, o_tuser, o_s0r, o_s1r, o_tp, o_busy}), 32'h0);
        chk("rst_tdata", o_tdata, 32'h0);
        chk("rst_fc", 32'(o_fc), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        tick();
        chk("arb_busy", 32'(busy_s), 32'h1);
        chk("arb_no_beat", 32'(obs_q.size()), 32'h0);
        repeat (3) tick();
        chk("f1_beats", 32'(obs_q.size()), 32'h3);
        for (int i = 0; i < 3; i++) begin
            chk("f1_user", 32'(obs_q[i].user), 32'h0);
            chk("f1_data", obs_q[i].data, 32'hA1 + 32'(i));
            chk("f1_last", 32'(obs_q[i].last), (i == 2) ? 32'h1 : 32'h0);
        end
        chk("f1_fc", 32'(o_fc), 32'h1);
        // Count ticks from the tlast tick (inclusive) to the tick that lands in IDLE
        n = 1;
        while (busy_s && n < 20) begin tick(); n++; end
        chk("gap_to_idle", 32'(n), 32'd5);

        // Round robin: both sources always valid, 2-beat frames
        do_reset();
        q0.push_back({1'b0, 32'h100}); q0.push_back({1'b1, 32'h101});
        q0.push_back({1'b0, 32'h102}); q0.push_back({1'b1, 32'h103});
        q1.push_back({1'b0, 32'h200}); q1.push_back({1'b1, 32'h201});
        q1.push_back({1'b0, 32'h202}); q1.push_back({1'b1, 32'h203});
        n = 0;
        while (obs_q.size() < 8 && n < 100) begin tick(); n++; end
        chk("rr_beats", 32'(obs_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
            chk("rr_data", obs_q[i].data, rr_d[i]);
            chk("rr_user", 32'(obs_q[i].user), 32'(rr_u[i]));
        end
        n = 0;
        while (busy_s && n < 20) begin tick(); n++; end
        chk("rr_fc", 32'(o_fc), 32'd4);

        // Backpressure on an s1 frame
        obs_q.delete();
        r0_seen = 1'b0;
        tp_cnt  = 0;
        for (int i = 0; i < 4; i++) q1.push_back({(i == 3), 32'hD0 + 32'(i)});
        for (int k = 0; k < 60 && (q1.size() > 0 || busy_s); k++) begin
            m_tready = k[0];
            tick();
        end
        m_tready = 1'b1;
        chk("bp_beats", 32'(obs_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            chk("bp_data", obs_q[i].data, 32'hD0 + 32'(i));
            chk("bp_user", 32'(obs_q[i].user), 32'h1);
        end
        chk("bp_s0_ready", 32'(r0_seen), 32'h0);
        chk("bp_no_timeout", 32'(tp_cnt), 32'h0);
        chk("bp_fc", 32'(o_fc), 32'd5);

        // Timeout: s0 stalls after two beats while s1 waits
        obs_q.delete();
        q0.push_back({1'b0, 32'hE0});
        q0.push_back({1'b0, 32'hE1});
        q1.push_back({1'b1, 32'hF0});
        repeat (3) tick();
        chk("tmo_beats", 32'(obs_q.size()), 32'd2);
        chk("tmo_user", 32'(obs_q[1].user), 32'h0);
        n = 0;
        while (!tp_seen && n < 100) begin tick(); n++; end
        chk("tmo_tick", 32'(n), 32'd64);
        chk("tmo_one_clk", 32'(tp_after), 32'h0);
        chk("tmo_fc", 32'(o_fc), 32'd5);
        chk("tmo_busy", 32'(busy_s), 32'h1);
        n = 0;
        while (obs_q.size() < 3 && n < 20) begin tick(); n++; end
        chk("tmo_s1_latency", 32'(n), 32'd6);
        chk("tmo_s1_data", (obs_q.size() > 2) ? obs_q[2].data : 32'hX, 32'hF0);
        chk("tmo_s1_user", (obs_q.size() > 2) ? 32'(obs_q[2].user) : 32'hX, 32'h1);
        n = 0;
        while (busy_s && n < 20) begin tick(); n++; end
        chk("tmo_fc_after", 32'(o_fc), 32'd6);

        // Zero gap instance, back-to-back frames from s0
        sel_z = 1'b1;
        do_reset();
        q0.push_back({1'b1, 32'h61});
        q0.push_back({1'b1, 32'h62});
        repeat (2) tick();
        chk("zg_first", 32'(obs_q.size()), 32'd1);
        chk("zg_idle_after_last", 32'(busy_s), 32'h0);
        n = 0;
        while (obs_q.size() < 2 && n < 20) begin tick(); n++; end
        chk("zg_spacing", 32'(n), 32'd2);
        chk("zg_data", (obs_q.size() > 1) ? obs_q[1].data : 32'hX, 32'h62);
        chk("zg_fc", 32'(o_fc), 32'd2);

        // Reset mid-frame
        sel_z = 1'b0;
        do_reset();
        q0.push_back({1'b1, 32'h70});
        q0.push_back({1'b0, 32'h71});
        q0.push_back({1'b0, 32'h72});
        q0.push_back({1'b1, 32'h73});
        repeat (2) tick();
        n = 0;
        while (busy_s && n < 20) begin tick(); n++; end
        repeat (2) tick();
        chk("mid_fc_pre", 32'(o_fc), 32'd1);
        chk("mid_tvalid_pre", 32'(o_tvalid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_ctrl", 32'({o_tvalid, o_tlast, o_tuser, o_s0r, o_s1r, o_tp, o_busy}), 32'h0);
        chk("mid_tdata", o_tdata, 32'h0);
        chk("mid_fc", 32'(o_fc), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        obs_q.delete();
        drive();
        @(negedge clk);

        // Counter wrap from a preloaded 0xFFFF
        force dut_a.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut_a.frame_cnt;
        @(negedge clk);
        chk("wrap_preload", 32'(o_fc), 32'hFFFF);
        q0.push_back({1'b1, 32'h80});
        repeat (2) tick();
        chk("wrap_data", (obs_q.size() > 0) ? obs_q[0].data : 32'hX, 32'h80);
        chk("wrap_fc", 32'(o_fc), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
